line_clear_engine: RTL and testbench

- Sits directly downstream of the playfield background stage; consumes its settled 400-bit field once a falling piece has locked.
- Scans the field row by row, removes every full row, shifts rows above it down, and presents the compacted field plus line count and running score to the field register and display path.
- Multi-cycle: one row check or one row-shift per clock, with a start/busy/done handshake.

---
 rtl/line_clear_engine_pkg.sv | 42 ++++
 rtl/field_row_shifter.sv | 27 ++
 rtl/line_clear_engine.sv | 113 +++++++++++
 tb/tb_line_clear_engine.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/line_clear_engine_pkg.sv
// Shared definitions for the line clear engine.
//   ROWS, COLS, FIELD_W : playfield geometry; row r lives at bits [r*COLS +: COLS], row 0 on top
//   PTR_W, CNT_W        : widths of the row pointer and of the cleared-line count
//   state_e             : controller states
//   points()            : score awarded for k rows cleared in one pass
//   row()               : extracts one row from a packed field
package line_clear_engine_pkg;

   localparam int unsigned ROWS    = 20;
   localparam int unsigned COLS    = 20;
   localparam int unsigned FIELD_W = ROWS * COLS;
   localparam int unsigned PTR_W   = 5;
   localparam int unsigned CNT_W   = 5;

   localparam logic [3:0] POINTS_0   = 4'd0;
   localparam logic [3:0] POINTS_1   = 4'd1;
   localparam logic [3:0] POINTS_2   = 4'd3;
   localparam logic [3:0] POINTS_3   = 4'd5;
   localparam logic [3:0] POINTS_MAX = 4'd8;

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DONE
   } state_e;

   function automatic logic [3:0] points(input logic [CNT_W-1:0] k);
      case (k)
         5'd0:    points = POINTS_0;
         5'd1:    points = POINTS_1;
         5'd2:    points = POINTS_2;
         5'd3:    points = POINTS_3;
         default: points = POINTS_MAX;
      endcase
   endfunction

   function automatic logic [COLS-1:0] row(input logic [FIELD_W-1:0] field,
                                           input logic [PTR_W-1:0]   r);
      row = field[r*COLS +: COLS];
   endfunction

endpackage

// File: rtl/field_row_shifter.sv
// Combinational row test and shift network.
//   field    : working field
//   ptr      : row under test
//   row_full : row[ptr] is all ones
//   shifted  : field with rows 0..ptr-1 moved down one and row 0 cleared (row[ptr] discarded)
module field_row_shifter
   import line_clear_engine_pkg::*;
(
   input  logic [FIELD_W-1:0] field,
   input  logic [PTR_W-1:0]   ptr,
   output logic               row_full,
   output logic [FIELD_W-1:0] shifted
);

   always_comb begin
      row_full = &row(field, ptr);
      shifted  = field;
      // With ptr=0 this simply clears row 0 in place.
      shifted[0 +: COLS] = '0;
      for (int r = 1; r < ROWS; r++) begin
         if (PTR_W'(r) <= ptr) begin
            shifted[r*COLS +: COLS] = row(field, PTR_W'(r - 1));
         end
      end
   end

endmodule

// File: rtl/line_clear_engine.sv
// Removes full rows from a captured playfield, compacts it, and accumulates a saturating score.
//   clk, reset    : clock; asynchronous active-high reset
//   start         : request a pass, accepted only in IDLE
//   field_in      : field from the background stage, captured on accept
//   busy, done    : busy from accept through the DONE cycle; done is a one-cycle pulse
//   field_out     : compacted field, held until the next done
//   lines_cleared : rows removed in the last pass
//   score         : running saturating score
module line_clear_engine
   import line_clear_engine_pkg::*;
#(
   parameter int unsigned SCORE_W = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic [FIELD_W-1:0] field_in,
   output logic               busy,
   output logic               done,
   output logic [FIELD_W-1:0] field_out,
   output logic [CNT_W-1:0]   lines_cleared,
   output logic [SCORE_W-1:0] score
);

   state_e               state_q, state_d;
   logic [FIELD_W-1:0]   work_q, work_d;
   logic [PTR_W-1:0]     ptr_q, ptr_d;
   logic [CNT_W-1:0]     k_q, k_d;
   logic [FIELD_W-1:0]   field_out_q, field_out_d;
   logic [CNT_W-1:0]     lines_q, lines_d;
   logic [SCORE_W-1:0]   score_q, score_d;

   logic                 row_full;
   logic [FIELD_W-1:0]   shifted;
   logic [SCORE_W:0]     score_sum;

   field_row_shifter u_shifter (
      .field    (work_q),
      .ptr      (ptr_q),
      .row_full (row_full),
      .shifted  (shifted)
   );

   always_comb begin
      state_d     = state_q;
      work_d      = work_q;
      ptr_d       = ptr_q;
      k_d         = k_q;
      field_out_d = field_out_q;
      lines_d     = lines_q;
      score_d     = score_q;
      // One extra bit catches the carry that triggers saturation.
      score_sum   = {1'b0, score_q} + {{(SCORE_W - 3){1'b0}}, points(k_q)};

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = SCAN;
               work_d  = field_in;
               ptr_d   = PTR_W'(ROWS - 1);
               k_d     = '0;
            end
         end
         SCAN: begin
            if (row_full) begin
               // ptr holds so the row shifted into place is tested next.
               work_d = shifted;
               k_d    = k_q + 1'b1;
            end else if (ptr_q != '0) begin
               ptr_d = ptr_q - 1'b1;
            end else begin
               state_d     = DONE;
               field_out_d = work_q;
               lines_d     = k_q;
               score_d     = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         work_q      <= '0;
         ptr_q       <= '0;
         k_q         <= '0;
         field_out_q <= '0;
         lines_q     <= '0;
         score_q     <= '0;
      end else begin
         state_q     <= state_d;
         work_q      <= work_d;
         ptr_q       <= ptr_d;
         k_q         <= k_d;
         field_out_q <= field_out_d;
         lines_q     <= lines_d;
         score_q     <= score_d;
      end
   end

   assign busy          = (state_q != IDLE);
   assign done          = (state_q == DONE);
   assign field_out     = field_out_q;
   assign lines_cleared = lines_q;
   assign score         = score_q;

endmodule

// File: tb/tb_line_clear_engine.sv
// Scoreboard bench: stimulus pushes expected results, a monitor pops and compares on done.
// A second instance with a 4-bit score exercises saturation quickly.
module tb_line_clear_engine;
   import line_clear_engine_pkg::*;

   logic               clk;
   logic               reset;
   logic               start;
   logic [FIELD_W-1:0] field_in;

   logic               busy, done, busy4, done4;
   logic [FIELD_W-1:0] field_out, field_out4;
   logic [CNT_W-1:0]   lines, lines4;
   logic [15:0]        score;
   logic [3:0]         score4;

   line_clear_engine #(.SCORE_W(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .field_in      (field_in),
      .busy          (busy),
      .done          (done),
      .field_out     (field_out),
      .lines_cleared (lines),
      .score         (score)
   );

   line_clear_engine #(.SCORE_W(4)) dut4 (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .field_in      (field_in),
      .busy          (busy4),
      .done          (done4),
      .field_out     (field_out4),
      .lines_cleared (lines4),
      .score         (score4)
   );

   typedef struct {
      logic [FIELD_W-1:0] fo;
      logic [CNT_W-1:0]   lines;
      logic [15:0]        s16;
      logic [3:0]         s4;
      int                 done_cyc;
   } exp_t;

   exp_t sbq[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc    = 0;
   int   m_s16  = 0;
   int   m_s4   = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [FIELD_W-1:0] act,
                        input logic [FIELD_W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: keep non-full rows in bottom-up order, packed against the bottom.
   task automatic model(input logic [FIELD_W-1:0] f, output logic [FIELD_W-1:0] o,
                        output int k);
      logic [COLS-1:0] rv;
      int dst;
      o   = '0;
      k   = 0;
      dst = ROWS - 1;
      for (int r = ROWS - 1; r >= 0; r--) begin
         rv = f[r*COLS +: COLS];
         if (&rv) k++;
         else begin
            o[dst*COLS +: COLS] = rv;
            dst--;
         end
      end
   endtask

   function automatic int pts(input int k);
      int tbl[5] = '{0, 1, 3, 5, 8};
      return (k > 4) ? 8 : tbl[k];
   endfunction

   // Monitor
   logic done_prev = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (done_prev && done) check("done_pulse_width", 400'(done), 400'(0));
         if (done) begin
            check("done_both_widths", 400'(done4), 400'(1));
            if (sbq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: got done=1 expected no pass at cycle %0d", cyc);
            end else begin
               e = sbq.pop_front();
               check("field_out", field_out, e.fo);
               check("field_out_w4", field_out4, e.fo);
               check("lines_cleared", 400'(lines), 400'(e.lines));
               check("score16", 400'(score), 400'(e.s16));
               check("score4_sat", 400'(score4), 400'(e.s4));
               check("latency_cycle", 400'(cyc), 400'(e.done_cyc));
            end
         end
      end
      done_prev <= done;
   end

   task automatic run_pass(input logic [FIELD_W-1:0] f, input bit poke_scan,
                           input bit poke_done);
      exp_t e;
      int   k;
      int   n;
      model(f, e.fo, k);
      m_s16      = (m_s16 + pts(k) > 65535) ? 65535 : m_s16 + pts(k);
      m_s4       = (m_s4 + pts(k) > 15) ? 15 : m_s4 + pts(k);
      e.lines    = CNT_W'(k);
      e.s16      = 16'(m_s16);
      e.s4       = 4'(m_s4);
      e.done_cyc = cyc + 1 + ROWS + k;
      sbq.push_back(e);
      start    = 1'b1;
      field_in = f;
      @(negedge clk);
      start    = 1'b0;
      // Post-capture changes must not matter.
      for (int r = 0; r < ROWS; r++) field_in[r*COLS +: COLS] = COLS'($urandom);
      if (poke_scan) begin
         repeat (3) @(negedge clk);
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
      end
      n = 0;
      while (!done && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got no done expected done within 100 cycles");
      end
      if (poke_done) start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check("idle_after_done", 400'(busy), 400'(0));
      @(negedge clk);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_busy"}, 400'(busy), 400'(0));
      check({tag, "_done"}, 400'(done), 400'(0));
      check({tag, "_field_out"}, field_out, '0);
      check({tag, "_lines"}, 400'(lines), 400'(0));
      check({tag, "_score"}, 400'(score), 400'(0));
      check({tag, "_score4"}, 400'(score4), 400'(0));
   endtask

   initial begin
      logic [FIELD_W-1:0] f;
      logic [COLS-1:0]    ones;
      int x;
      ones     = '1;
      reset    = 1'b1;
      start    = 1'b0;
      field_in = '0;
      #1;
      check_reset_state("reset");
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Empty field
      run_pass('0, 1'b0, 1'b0);

      // Single bottom line
      f = '0;
      f[19*COLS +: COLS] = ones;
      f[18*COLS +: COLS] = 20'h00001;
      run_pass(f, 1'b0, 1'b0);

      // Non-adjacent rows, start poked mid-scan
      f = '0;
      f[19*COLS +: COLS] = ones;
      f[17*COLS +: COLS] = ones;
      f[15*COLS +: COLS] = ones;
      f[10*COLS +: COLS] = ones;
      f[16*COLS +: COLS] = 20'h80000;
      run_pass(f, 1'b1, 1'b0);

      // Full field, start poked in the DONE cycle; saturates the 4-bit score
      run_pass('1, 1'b0, 1'b1);

      // Reset during step 5 of a pass
      f = '0;
      f[19*COLS +: COLS] = ones;
      start    = 1'b1;
      field_in = f;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      check_reset_state("mid_scan_reset");
      m_s16 = 0;
      m_s4  = 0;
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Fresh pass after reset
      f = '0;
      f[19*COLS +: COLS] = ones;
      f[18*COLS +: COLS] = 20'h00001;
      run_pass(f, 1'b0, 1'b0);

      // Randomized passes
      for (int p = 0; p < 30; p++) begin
         for (int r = 0; r < ROWS; r++) begin
            x = $urandom_range(0, 9);
            if (x < 3) f[r*COLS +: COLS] = ones;
            else if (x < 5) f[r*COLS +: COLS] = '0;
            else f[r*COLS +: COLS] = COLS'($urandom);
         end
         run_pass(f, 1'(($urandom & 32'd3) == 0), 1'(($urandom & 32'd3) == 0));
      end

      repeat (5) @(negedge clk);
      check("scoreboard_drained", 400'(sbq.size()), 400'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
